// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants: default 640x480@60 timing, derived totals and sync edges.
// Pure definitions, no logic; imported by the timing generator and its delay line.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
    localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

    typedef logic [9:0] coord_t;

    // Idle value of the {hs, vs, blank} bundle: syncs deasserted, not visible.
    localparam logic [2:0] SYNC_IDLE = 3'b110;

    function automatic coord_t to_coord(input int v);
        return coord_t'(v);
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Purpose: DEPTH-stage shift register with a configurable reset value (DEPTH >= 1).
// Latency: DEPTH cycles. Backpressure: none, shifts every cycle.
module sync_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_dat,
    output logic [WIDTH-1:0] out_dat
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = in_dat;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= reset ? RST_VAL : stage_d[i];
        end
    end

    assign out_dat = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: VGA raster counters with registered coordinates, blank, syncs, frame strobe/count.
// Latency: hs/vs/blank coincident with DrawX/DrawY; *_d follow after PIPE_DELAY cycles.
// Backpressure: none, free-running every pixel clock.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int PIPE_DELAY = 2
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic [7:0] frame_count,
    output logic       hs_d,
    output logic       vs_d,
    output logic       blank_d
);

    localparam int     H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int     V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam coord_t H_LAST   = to_coord(H_TOTAL - 1);
    localparam coord_t V_LAST   = to_coord(V_TOTAL - 1);
    localparam coord_t H_ACT    = to_coord(H_ACTIVE);
    localparam coord_t V_ACT    = to_coord(V_ACTIVE);
    localparam coord_t HS_START = to_coord(H_ACTIVE + H_FP);
    localparam coord_t HS_END   = to_coord(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_START = to_coord(V_ACTIVE + V_FP);
    localparam coord_t VS_END   = to_coord(V_ACTIVE + V_FP + V_SYNC - 1);

    coord_t     h_q, h_d, v_q, v_d;
    logic       vis_q, vis_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       fstart_q, fstart_d;
    logic [7:0] fcount_q, fcount_d;
    logic [2:0] sync_dat, sync_dly_dat;

    // Every flag is derived from the next position so it lands on the same edge as the counters.
    always_comb begin
        h_d = (h_q == H_LAST) ? '0 : h_q + 10'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end
        vis_d    = (h_d < H_ACT) && (v_d < V_ACT);
        hsync_d  = !((h_d >= HS_START) && (h_d <= HS_END));
        vsync_d  = !((v_d >= VS_START) && (v_d <= VS_END));
        fstart_d = (h_d == '0) && (v_d == '0);
        fcount_d = fstart_d ? fcount_q + 8'd1 : fcount_q;
    end

    // Reset parks on the last position so the first free edge lands on (0,0) as frame 0.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            h_q      <= H_LAST;
            v_q      <= V_LAST;
            vis_q    <= 1'b0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            fstart_q <= 1'b0;
            fcount_q <= 8'hFF;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            vis_q    <= vis_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            fstart_q <= fstart_d;
            fcount_q <= fcount_d;
        end
    end

    assign DrawX       = h_q;
    assign DrawY       = v_q;
    assign blank       = vis_q;
    assign hs          = hsync_q;
    assign vs          = vsync_q;
    assign frame_start = fstart_q;
    assign frame_count = fcount_q;

    assign sync_dat = {hsync_q, vsync_q, vis_q};

    generate
        if (PIPE_DELAY == 0) begin : g_no_dly
            assign sync_dly_dat = sync_dat;
        end else begin : g_dly
            sync_delay_line #(
                .WIDTH  (3),
                .DEPTH  (PIPE_DELAY),
                .RST_VAL(SYNC_IDLE)
            ) u_sync_dly (
                .clk    (vga_clk),
                .reset  (reset),
                .in_dat (sync_dat),
                .out_dat(sync_dly_dat)
            );
        end
    endgenerate

    assign {hs_d, vs_d, blank_d} = sync_dly_dat;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: full-width lines with a short frame (800x55, delay 2) plus a tiny 8x4 raster (delay 0).
module tb_vga_timing_gen;

    logic vga_clk = 1'b0;
    logic reset   = 1'b1;
    always #5 vga_clk = ~vga_clk;

    logic [9:0] a_x, a_y, b_x, b_y;
    logic       a_bl, a_hs, a_vs, a_fs, a_hsd, a_vsd, a_bld;
    logic       b_bl, b_hs, b_vs, b_fs, b_hsd, b_vsd, b_bld;
    logic [7:0] a_fc, b_fc;

    // 800 x 55 raster: active 48 lines, vsync on lines 50..51.
    vga_timing_gen #(
        .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_DELAY(2)
    ) dut_a (
        .vga_clk(vga_clk), .reset(reset), .DrawX(a_x), .DrawY(a_y), .blank(a_bl),
        .hs(a_hs), .vs(a_vs), .frame_start(a_fs), .frame_count(a_fc),
        .hs_d(a_hsd), .vs_d(a_vsd), .blank_d(a_bld)
    );

    // 8 x 4 raster, 32 cycles per frame.
    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(0), .PIPE_DELAY(0)
    ) dut_b (
        .vga_clk(vga_clk), .reset(reset), .DrawX(b_x), .DrawY(b_y), .blank(b_bl),
        .hs(b_hs), .vs(b_vs), .frame_start(b_fs), .frame_count(b_fc),
        .hs_d(b_hsd), .vs_d(b_vsd), .blank_d(b_bld)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int cyc; int x; int y; int bl; int hs; int vs; int fs; int fc;
    } vec_t;

    // mcyc = k at the falling edge after the k-th rising edge since reset was released.
    logic       rst_s = 1'b1;
    int         mcyc  = 0;
    bit         pass1 = 1'b1;
    logic [2:0] hist1 = 3'b110;
    logic [2:0] hist2 = 3'b110;
    int a_vs_lo = 0, a_hs_lo = 0, a_bl_hi = 0, a_bl_late = 0, a_fs_n = 0, a_dly_bad = 0;
    int b_pos_bad = 0, b_dly_bad = 0, b_per_bad = 0, b_fc_bad = 0;
    int b_wraps = 0, b_nfs = 0, b_last_fs = 0, b_exp_fc = 0;

    always @(posedge vga_clk) rst_s <= reset;

    always @(negedge vga_clk) begin
        mcyc = rst_s ? 0 : mcyc + 1;
        if (pass1 && !rst_s) begin
            if (mcyc <= 44000) begin
                if (!a_vs) a_vs_lo++;
                if (!a_hs) a_hs_lo++;
                if (a_bl) a_bl_hi++;
                if (a_bl && a_y >= 10'd48) a_bl_late++;
            end
            if (mcyc <= 44001 && a_fs) a_fs_n++;
            if ({a_hsd, a_vsd, a_bld} != hist2) a_dly_bad++;

            if (int'(b_x) != (mcyc - 1) % 8 || int'(b_y) != ((mcyc - 1) / 8) % 4 ||
                int'(b_fs) != int'((mcyc - 1) % 32 == 0)) b_pos_bad++;
            if ({b_hsd, b_vsd, b_bld} != {b_hs, b_vs, b_bl}) b_dly_bad++;
            if (b_fs) begin
                if (b_nfs > 0 && mcyc - b_last_fs != 32) b_per_bad++;
                if (int'(b_fc) != b_exp_fc) b_fc_bad++;
                if (b_nfs > 0 && b_fc == 8'd0) b_wraps++;
                b_exp_fc  = (b_exp_fc + 1) % 256;
                b_nfs++;
                b_last_fs = mcyc;
            end
        end
        hist2 = hist1;
        hist1 = {a_hs, a_vs, a_bl};
    end

    task automatic chk_a(input string tag, input int x, input int y, input int bl, input int hs,
                         input int vs, input int fs, input int fc);
        chk({tag, ".x"},  int'(a_x),  x);
        chk({tag, ".y"},  int'(a_y),  y);
        chk({tag, ".bl"}, int'(a_bl), bl);
        chk({tag, ".hs"}, int'(a_hs), hs);
        chk({tag, ".vs"}, int'(a_vs), vs);
        chk({tag, ".fs"}, int'(a_fs), fs);
        chk({tag, ".fc"}, int'(a_fc), fc);
    endtask

    task automatic wait_cyc(input int target);
        int g;
        g = 0;
        while (mcyc < target && g < 70000) begin
            @(negedge vga_clk);
            #1;
            g++;
        end
        if (mcyc != target) chk("cycle_budget", mcyc, target);
    endtask

    initial begin
        vec_t tbl[18];
        tbl[0]  = '{1,     0,   0,  1, 1, 1, 1, 0};
        tbl[1]  = '{2,     1,   0,  1, 1, 1, 0, 0};
        tbl[2]  = '{640,   639, 0,  1, 1, 1, 0, 0};
        tbl[3]  = '{641,   640, 0,  0, 1, 1, 0, 0};
        tbl[4]  = '{656,   655, 0,  0, 1, 1, 0, 0};
        tbl[5]  = '{657,   656, 0,  0, 0, 1, 0, 0};
        tbl[6]  = '{752,   751, 0,  0, 0, 1, 0, 0};
        tbl[7]  = '{753,   752, 0,  0, 1, 1, 0, 0};
        tbl[8]  = '{800,   799, 0,  0, 1, 1, 0, 0};
        tbl[9]  = '{801,   0,   1,  1, 1, 1, 0, 0};
        tbl[10] = '{38080, 479, 47, 1, 1, 1, 0, 0};
        tbl[11] = '{38401, 0,   48, 0, 1, 1, 0, 0};
        tbl[12] = '{40001, 0,   50, 0, 1, 0, 0, 0};
        tbl[13] = '{40657, 656, 50, 0, 0, 0, 0, 0};
        tbl[14] = '{41600, 799, 51, 0, 1, 0, 0, 0};
        tbl[15] = '{41601, 0,   52, 0, 1, 1, 0, 0};
        tbl[16] = '{44000, 799, 54, 0, 1, 1, 0, 0};
        tbl[17] = '{44001, 0,   0,  1, 1, 1, 1, 1};

        // Held in reset: parked at the last position with idle syncs.
        repeat (3) @(negedge vga_clk);
        #1;
        chk_a("rst", 799, 54, 0, 1, 1, 0, 255);
        chk("rst.hs_d",    int'(a_hsd), 1);
        chk("rst.vs_d",    int'(a_vsd), 1);
        chk("rst.blank_d", int'(a_bld), 0);
        chk("rst_b.x",     int'(b_x),   7);
        chk("rst_b.y",     int'(b_y),   3);
        chk("rst_b.fc",    int'(b_fc),  255);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            wait_cyc(tbl[i].cyc);
            chk_a($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].bl, tbl[i].hs,
                  tbl[i].vs, tbl[i].fs, tbl[i].fc);
        end
        pass1 = 1'b0;

        chk("frame.vs_low_cycles",   a_vs_lo,   1600);
        chk("frame.hs_low_cycles",   a_hs_lo,   55 * 96);
        chk("frame.visible_cycles",  a_bl_hi,   48 * 640);
        chk("frame.visible_late",    a_bl_late, 0);
        chk("frame.start_pulses",    a_fs_n,    2);
        chk("frame.delay2_mismatch", a_dly_bad, 0);
        chk("small.position_errs",   b_pos_bad, 0);
        chk("small.delay0_mismatch", b_dly_bad, 0);
        chk("small.period_errs",     b_per_bad, 0);
        chk("small.count_errs",      b_fc_bad,  0);
        chk("small.frames",          b_nfs,     1376);
        chk("small.count_wraps",     b_wraps,   5);

        // Mid-frame reset at (300,20) of the second frame.
        wait_cyc(60301);
        chk("mid.x",       int'(a_x),   300);
        chk("mid.y",       int'(a_y),   20);
        chk("mid.fc",      int'(a_fc),  1);
        chk("mid.blank_d", int'(a_bld), 1);
        reset = 1'b1;
        @(negedge vga_clk);
        #1;
        chk_a("mid_rst", 799, 54, 0, 1, 1, 0, 255);
        chk("mid_rst.blank_d", int'(a_bld), 0);
        chk("mid_rst.hs_d",    int'(a_hsd), 1);
        chk("mid_rst.vs_d",    int'(a_vsd), 1);
        reset = 1'b0;
        @(negedge vga_clk);
        #1;
        chk_a("restart", 0, 0, 1, 1, 1, 1, 0);
        chk("restart.blank_d", int'(a_bld), 0);
        @(negedge vga_clk);
        #1;
        chk("restart2.x",       int'(a_x),   1);
        chk("restart2.blank_d", int'(a_bld), 0);
        @(negedge vga_clk);
        #1;
        chk("restart3.blank_d", int'(a_bld), 1);
        chk("restart3.hs_d",    int'(a_hsd), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
